// File: rtl/tank_pkg.sv
// Shared types, keymap and start-position tables for the tank array controller.
package tank_pkg;

  localparam int MAX_TANKS = 4;

  // Screen extents, kept at 11 bits so box arithmetic never wraps
  localparam logic [10:0] SCREEN_W = 11'd640;
  localparam logic [10:0] SCREEN_H = 11'd480;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    FIRE_READY        = 2'd0,
    FIRE_COOLDOWN     = 2'd1,
    FIRE_WAIT_RELEASE = 2'd2
  } fire_state_t;

  typedef enum logic [2:0] {
    KEY_UP    = 3'd0,
    KEY_DOWN  = 3'd1,
    KEY_LEFT  = 3'd2,
    KEY_RIGHT = 3'd3,
    KEY_FIRE  = 3'd4
  } key_role_t;

  // USB HID keycode for a given tank and control role.
  // Each row is packed {fire, right, left, down, up}.
  function automatic logic [7:0] keymap(input int tank, input key_role_t role);
    logic [39:0] row;
    case (tank)
      0:       row = {8'h2C, 8'h07, 8'h04, 8'h16, 8'h1A};
      1:       row = {8'h58, 8'h4F, 8'h50, 8'h51, 8'h52};
      2:       row = {8'h11, 8'h0F, 8'h0D, 8'h0E, 8'h0C};
      default: row = {8'h62, 8'h5E, 8'h5C, 8'h5A, 8'h60};
    endcase
    return row[8*int'(role) +: 8];
  endfunction

  // Power-on X position of each tank
  function automatic logic [9:0] start_x(input int tank);
    logic [9:0] x;
    case (tank)
      0:       x = 10'd500;
      1:       x = 10'd100;
      2:       x = 10'd300;
      default: x = 10'd300;
    endcase
    return x;
  endfunction

  // Power-on Y position of each tank
  function automatic logic [9:0] start_y(input int tank);
    logic [9:0] y;
    case (tank)
      0:       y = 10'd240;
      1:       y = 10'd240;
      2:       y = 10'd100;
      default: y = 10'd380;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/tank_fire_fsm.sv
// Per-tank fire controller: one shot per press, a frame-counted cooldown,
// and a hold-off that requires the fire key to be released before re-arming.
module tank_fire_fsm
  import tank_pkg::*;
#(
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd30
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_tick,
  input  logic i_fireHeld,
  output logic o_firePulse
);

  fire_state_t r_state;
  logic [7:0]  r_count;

  // Advance the fire state once per frame tick; the shot strobe lasts one Clk
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= FIRE_READY;
      r_count     <= 8'd0;
      o_firePulse <= 1'b0;
    end else begin
      o_firePulse <= 1'b0;
      if (i_tick) begin
        case (r_state)
          FIRE_READY: begin
            if (i_fireHeld) begin
              o_firePulse <= 1'b1;
              r_count     <= COOLDOWN_FRAMES;
              r_state     <= FIRE_COOLDOWN;
            end
          end
          FIRE_COOLDOWN: begin
            if (r_count <= 8'd1) begin
              r_count <= 8'd0;
              r_state <= i_fireHeld ? FIRE_WAIT_RELEASE : FIRE_READY;
            end else begin
              r_count <= r_count - 8'd1;
            end
          end
          FIRE_WAIT_RELEASE: begin
            if (!i_fireHeld) begin
              r_state <= FIRE_READY;
            end
          end
          default: begin
            r_state <= FIRE_READY;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/tank_array_ctrl.sv
// Keyboard-driven movement, collision hold-off, firing and pixel hit test
// for a small array of tank sprites, all advanced once per video frame.
module tank_array_ctrl
  import tank_pkg::*;
#(
  parameter int          NUM_TANKS       = 2,
  parameter int          NUM_KEYS        = 6,
  parameter logic [9:0]  STEP            = 10'd1,
  parameter logic [9:0]  WIDTH           = 10'd32,
  parameter logic [9:0]  HEIGHT          = 10'd32,
  parameter logic [7:0]  COOLDOWN_FRAMES = 8'd30
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_clk,
  input  logic [NUM_KEYS*8-1:0]   keycodes,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic [NUM_TANKS*10-1:0] tank_X,
  output logic [NUM_TANKS*10-1:0] tank_Y,
  output logic [NUM_TANKS*3-1:0]  tank_dir,
  output logic [NUM_TANKS-1:0]    fire_pulse,
  output logic                    is_tank,
  output logic [1:0]              tank_id
);

  localparam logic [10:0] W11   = {1'b0, WIDTH};
  localparam logic [10:0] H11   = {1'b0, HEIGHT};
  localparam logic [10:0] S11   = {1'b0, STEP};
  localparam logic [10:0] MAX_X = SCREEN_W - W11;
  localparam logic [10:0] MAX_Y = SCREEN_H - H11;

  logic [1:0] r_rstSync;
  logic       r_frameMeta;
  logic       r_frameSync;
  logic       r_framePrev;
  logic       w_frameTick;

  logic [9:0] r_posX [NUM_TANKS];
  logic [9:0] r_posY [NUM_TANKS];
  dir_t       r_dir  [NUM_TANKS];

  logic [10:0]          w_candX   [NUM_TANKS];
  logic [10:0]          w_candY   [NUM_TANKS];
  dir_t                 w_newDir  [NUM_TANKS];
  logic [NUM_TANKS-1:0] w_move;
  logic [NUM_TANKS-1:0] w_fireHeld;
  logic [NUM_TANKS-1:0] w_blocked;

  // True when any report slot carries the given non-empty keycode
  function automatic logic keyHeld(input logic [NUM_KEYS*8-1:0] codes,
                                   input logic [7:0] key);
    logic held;
    held = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key != 8'h00 && codes[8*k +: 8] == key) begin
        held = 1'b1;
      end
    end
    return held;
  endfunction

  // Inclusive-extent box overlap, widened so X+WIDTH-1 cannot wrap
  function automatic logic boxOverlap(input logic [10:0] ax, input logic [10:0] ay,
                                      input logic [10:0] bx, input logic [10:0] by);
    return (ax <= bx + W11 - 11'd1) && (bx <= ax + W11 - 11'd1) &&
           (ay <= by + H11 - 11'd1) && (by <= ay + H11 - 11'd1);
  endfunction

  // Reset release is re-timed to Clk; no frame tick is honoured until it completes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  // Two-flop synchroniser for the frame strobe plus a delayed copy for edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_frameMeta <= 1'b0;
      r_frameSync <= 1'b0;
      r_framePrev <= 1'b0;
    end else begin
      r_frameMeta <= frame_clk;
      r_frameSync <= r_frameMeta;
      r_framePrev <= r_frameSync;
    end
  end

  assign w_frameTick = r_rstSync[1] & r_frameSync & ~r_framePrev;

  // Decode keys per tank and form the clamped candidate position for this frame
  always_comb begin
    for (int i = 0; i < NUM_TANKS; i++) begin
      w_candX[i]    = {1'b0, r_posX[i]};
      w_candY[i]    = {1'b0, r_posY[i]};
      w_newDir[i]   = r_dir[i];
      w_move[i]     = 1'b0;
      w_fireHeld[i] = keyHeld(keycodes, keymap(i, KEY_FIRE));
      if (keyHeld(keycodes, keymap(i, KEY_UP))) begin
        w_move[i]   = 1'b1;
        w_newDir[i] = DIR_UP;
        w_candY[i]  = ({1'b0, r_posY[i]} < S11) ? 11'd0 : {1'b0, r_posY[i]} - S11;
      end else if (keyHeld(keycodes, keymap(i, KEY_DOWN))) begin
        w_move[i]   = 1'b1;
        w_newDir[i] = DIR_DOWN;
        w_candY[i]  = ({1'b0, r_posY[i]} + S11 > MAX_Y) ? MAX_Y : {1'b0, r_posY[i]} + S11;
      end else if (keyHeld(keycodes, keymap(i, KEY_LEFT))) begin
        w_move[i]   = 1'b1;
        w_newDir[i] = DIR_LEFT;
        w_candX[i]  = ({1'b0, r_posX[i]} < S11) ? 11'd0 : {1'b0, r_posX[i]} - S11;
      end else if (keyHeld(keycodes, keymap(i, KEY_RIGHT))) begin
        w_move[i]   = 1'b1;
        w_newDir[i] = DIR_RIGHT;
        w_candX[i]  = ({1'b0, r_posX[i]} + S11 > MAX_X) ? MAX_X : {1'b0, r_posX[i]} + S11;
      end
    end
  end

  // A candidate touching any other tank's present or intended box is rejected
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < NUM_TANKS; i++) begin
      for (int j = 0; j < NUM_TANKS; j++) begin
        if (i != j) begin
          if (boxOverlap(w_candX[i], w_candY[i], {1'b0, r_posX[j]}, {1'b0, r_posY[j]}) ||
              boxOverlap(w_candX[i], w_candY[i], w_candX[j], w_candY[j])) begin
            w_blocked[i] = 1'b1;
          end
        end
      end
    end
  end

  // Commit facing on any move key, and position only when the move is clear
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_TANKS; i++) begin
        r_posX[i] <= start_x(i);
        r_posY[i] <= start_y(i);
        r_dir[i]  <= DIR_UP;
      end
    end else if (w_frameTick) begin
      for (int i = 0; i < NUM_TANKS; i++) begin
        if (w_move[i]) begin
          r_dir[i] <= w_newDir[i];
          if (!w_blocked[i]) begin
            r_posX[i] <= w_candX[i][9:0];
            r_posY[i] <= w_candY[i][9:0];
          end
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_TANKS; g++) begin : gen_tank
      assign tank_X[g*10 +: 10] = r_posX[g];
      assign tank_Y[g*10 +: 10] = r_posY[g];
      assign tank_dir[g*3 +: 3] = r_dir[g];

      tank_fire_fsm #(
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
      ) u_fire (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .i_tick      (w_frameTick),
        .i_fireHeld  (w_fireHeld[g]),
        .o_firePulse (fire_pulse[g])
      );
    end
  endgenerate

  // Pixel hit test; scanning from the top index down leaves the lowest hit
  always_comb begin
    is_tank = 1'b0;
    tank_id = 2'd0;
    for (int i = NUM_TANKS - 1; i >= 0; i--) begin
      if ({1'b0, DrawX} >= {1'b0, r_posX[i]} && {1'b0, DrawX} <= {1'b0, r_posX[i]} + W11 - 11'd1 &&
          {1'b0, DrawY} >= {1'b0, r_posY[i]} && {1'b0, DrawY} <= {1'b0, r_posY[i]} + H11 - 11'd1) begin
        is_tank = 1'b1;
        tank_id = 2'(i);
      end
    end
  end

endmodule

// File: tb/tb_tank_array_ctrl.sv
// Directed bench for tank_array_ctrl: movement, clamping, head-on hold,
// fire cooldown/release, asynchronous reset and the pixel hit test.
module tb_tank_array_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        frame_clk;
  logic [47:0] keycodes;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [19:0] tank_X;
  logic [19:0] tank_Y;
  logic [5:0]  tank_dir;
  logic [1:0]  fire_pulse;
  logic        is_tank;
  logic [1:0]  tank_id;

  int passCount  = 0;
  int checkCount = 0;
  int pulses0    = 0;
  int pulses1    = 0;

  tank_array_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .keycodes   (keycodes),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .tank_X     (tank_X),
    .tank_Y     (tank_Y),
    .tank_dir   (tank_dir),
    .fire_pulse (fire_pulse),
    .is_tank    (is_tank),
    .tank_id    (tank_id)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count one tally per Clk the shot strobe is seen high
  always @(negedge Clk) begin
    if (fire_pulse[0] === 1'b1) pulses0++;
    if (fire_pulse[1] === 1'b1) pulses1++;
  end

  task automatic applyReset();
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    keycodes  = '0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic applyFrames(input int n);
    for (int f = 0; f < n; f++) begin
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    applyReset();
    checkCount++;
    if ({tank_X, tank_Y} !== {10'd100, 10'd500, 10'd240, 10'd240})
      $display("[TB] FAIL reset_pos got X=%h Y=%h expected X=%h Y=%h", tank_X, tank_Y,
               {10'd100, 10'd500}, {10'd240, 10'd240});
    else passCount++;
    checkCount++;
    if (tank_dir !== 6'b001_001 || fire_pulse !== 2'b00)
      $display("[TB] FAIL reset_dir_fire got dir=%b pulse=%b expected dir=001001 pulse=00", tank_dir, fire_pulse);
    else passCount++;
  endtask

  task automatic test_move_up();
    applyReset();
    keycodes = 48'h1A;
    applyFrames(10);
    checkCount++;
    if (tank_Y[9:0] !== 10'd230 || tank_X[9:0] !== 10'd500 || tank_dir[2:0] !== 3'd1)
      $display("[TB] FAIL move_up got X=%0d Y=%0d dir=%0d expected X=500 Y=230 dir=1",
               tank_X[9:0], tank_Y[9:0], tank_dir[2:0]);
    else passCount++;
    checkCount++;
    if (tank_X[19:10] !== 10'd100 || tank_Y[19:10] !== 10'd240 || tank_dir[5:3] !== 3'd1)
      $display("[TB] FAIL move_up_other got X=%0d Y=%0d dir=%0d expected X=100 Y=240 dir=1",
               tank_X[19:10], tank_Y[19:10], tank_dir[5:3]);
    else passCount++;
  endtask

  task automatic test_priority();
    applyReset();
    keycodes = {16'h0, 8'h07, 8'h04, 8'h16, 8'h1A};
    applyFrames(3);
    checkCount++;
    if (tank_X[9:0] !== 10'd500 || tank_Y[9:0] !== 10'd237 || tank_dir[2:0] !== 3'd1)
      $display("[TB] FAIL prio_up got X=%0d Y=%0d dir=%0d expected X=500 Y=237 dir=1",
               tank_X[9:0], tank_Y[9:0], tank_dir[2:0]);
    else passCount++;
    keycodes = {24'h0, 8'h07, 8'h04, 8'h16};
    applyFrames(3);
    checkCount++;
    if (tank_X[9:0] !== 10'd500 || tank_Y[9:0] !== 10'd240 || tank_dir[2:0] !== 3'd4)
      $display("[TB] FAIL prio_down got X=%0d Y=%0d dir=%0d expected X=500 Y=240 dir=4",
               tank_X[9:0], tank_Y[9:0], tank_dir[2:0]);
    else passCount++;
    keycodes = {32'h0, 8'h07, 8'h04};
    applyFrames(3);
    checkCount++;
    if (tank_X[9:0] !== 10'd497 || tank_Y[9:0] !== 10'd240 || tank_dir[2:0] !== 3'd3)
      $display("[TB] FAIL prio_left got X=%0d Y=%0d dir=%0d expected X=497 Y=240 dir=3",
               tank_X[9:0], tank_Y[9:0], tank_dir[2:0]);
    else passCount++;
    keycodes = '0;
    applyFrames(2);
    checkCount++;
    if (tank_X[9:0] !== 10'd497 || tank_dir[2:0] !== 3'd3)
      $display("[TB] FAIL no_momentum got X=%0d dir=%0d expected X=497 dir=3", tank_X[9:0], tank_dir[2:0]);
    else passCount++;
  endtask

  task automatic test_clamp();
    applyReset();
    keycodes = 48'h07;
    applyFrames(107);
    checkCount++;
    if (tank_X[9:0] !== 10'd607)
      $display("[TB] FAIL clamp_pre got X=%0d expected 607", tank_X[9:0]);
    else passCount++;
    applyFrames(5);
    checkCount++;
    if (tank_X[9:0] !== 10'd608 || tank_dir[2:0] !== 3'd2)
      $display("[TB] FAIL clamp_right got X=%0d dir=%0d expected X=608 dir=2", tank_X[9:0], tank_dir[2:0]);
    else passCount++;
  endtask

  task automatic test_head_on();
    applyReset();
    keycodes = {32'h0, 8'h51, 8'h1A};
    applyFrames(40);
    keycodes = {32'h0, 8'h4F, 8'h04};
    applyFrames(133);
    keycodes = {32'h0, 8'h00, 8'h04};
    applyFrames(167);
    keycodes = {32'h0, 8'h52, 8'h16};
    applyFrames(40);
    checkCount++;
    if ({tank_X, tank_Y} !== {10'd233, 10'd200, 10'd240, 10'd240})
      $display("[TB] FAIL headon_setup got X=%h Y=%h expected X=%h Y=%h", tank_X, tank_Y,
               {10'd233, 10'd200}, {10'd240, 10'd240});
    else passCount++;
    keycodes = {32'h0, 8'h50, 8'h07};
    applyFrames(5);
    checkCount++;
    if ({tank_X, tank_Y} !== {10'd233, 10'd200, 10'd240, 10'd240})
      $display("[TB] FAIL headon_hold got X=%h Y=%h expected X=%h Y=%h", tank_X, tank_Y,
               {10'd233, 10'd200}, {10'd240, 10'd240});
    else passCount++;
    checkCount++;
    if (tank_dir !== {3'd3, 3'd2})
      $display("[TB] FAIL headon_dir got %b expected %b", tank_dir, {3'd3, 3'd2});
    else passCount++;
  endtask

  task automatic test_fire();
    int base;
    applyReset();
    base = pulses0;
    keycodes = 48'h2C;
    applyFrames(1);
    checkCount++;
    if (pulses0 - base !== 1)
      $display("[TB] FAIL fire_first got %0d pulses expected 1", pulses0 - base);
    else passCount++;
    applyFrames(29);
    checkCount++;
    if (pulses0 - base !== 1)
      $display("[TB] FAIL fire_cooldown got %0d pulses expected 1", pulses0 - base);
    else passCount++;
    keycodes = '0;
    applyFrames(1);
    keycodes = 48'h2C;
    applyFrames(1);
    checkCount++;
    if (pulses0 - base !== 2)
      $display("[TB] FAIL fire_repress got %0d pulses expected 2", pulses0 - base);
    else passCount++;
    applyFrames(38);
    checkCount++;
    if (pulses0 - base !== 2 || pulses1 !== 0)
      $display("[TB] FAIL fire_hold70 got %0d pulses (tank1 %0d) expected 2 (tank1 0)", pulses0 - base, pulses1);
    else passCount++;
    keycodes = '0;
    applyFrames(1);
    keycodes = 48'h2C;
    applyFrames(1);
    checkCount++;
    if (pulses0 - base !== 3)
      $display("[TB] FAIL fire_after_wait got %0d pulses expected 3", pulses0 - base);
    else passCount++;
  endtask

  task automatic test_reset_mid_cooldown();
    int base;
    applyReset();
    keycodes = {24'h0, 8'h04, 8'h52, 8'h2C};
    applyFrames(19);
    checkCount++;
    if (tank_X[9:0] !== 10'd481 || tank_Y[19:10] !== 10'd221 || tank_dir[2:0] !== 3'd3)
      $display("[TB] FAIL precond got X0=%0d Y1=%0d dir0=%0d expected 481 221 3",
               tank_X[9:0], tank_Y[19:10], tank_dir[2:0]);
    else passCount++;
    #2;
    Reset_n = 1'b0;
    #1;
    checkCount++;
    if ({tank_X, tank_Y, tank_dir, fire_pulse} !==
        {10'd100, 10'd500, 10'd240, 10'd240, 3'd1, 3'd1, 2'b00})
      $display("[TB] FAIL async_reset got X=%h Y=%h dir=%b pulse=%b expected reset values",
               tank_X, tank_Y, tank_dir, fire_pulse);
    else passCount++;
    repeat (3) @(negedge Clk);
    base = pulses0;
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    checkCount++;
    if (pulses0 - base !== 0)
      $display("[TB] FAIL early_pulse got %0d pulses expected 0", pulses0 - base);
    else passCount++;
    applyFrames(1);
    checkCount++;
    if (pulses0 - base !== 1 || tank_X[9:0] !== 10'd499)
      $display("[TB] FAIL post_reset_shot got %0d pulses X=%0d expected 1 pulse X=499", pulses0 - base, tank_X[9:0]);
    else passCount++;
  endtask

  task automatic test_pixel();
    applyReset();
    DrawX = 10'd500; DrawY = 10'd240;
    #1;
    checkCount++;
    if (is_tank !== 1'b1 || tank_id !== 2'd0)
      $display("[TB] FAIL pix_500_240 got is=%b id=%0d expected is=1 id=0", is_tank, tank_id);
    else passCount++;
    DrawX = 10'd532; DrawY = 10'd240;
    #1;
    checkCount++;
    if (is_tank !== 1'b0 || tank_id !== 2'd0)
      $display("[TB] FAIL pix_532_240 got is=%b id=%0d expected is=0 id=0", is_tank, tank_id);
    else passCount++;
    DrawX = 10'd131; DrawY = 10'd271;
    #1;
    checkCount++;
    if (is_tank !== 1'b1 || tank_id !== 2'd1)
      $display("[TB] FAIL pix_131_271 got is=%b id=%0d expected is=1 id=1", is_tank, tank_id);
    else passCount++;
    DrawX = 10'd131; DrawY = 10'd272;
    #1;
    checkCount++;
    if (is_tank !== 1'b0)
      $display("[TB] FAIL pix_131_272 got is=%b expected is=0", is_tank);
    else passCount++;
  endtask

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    keycodes  = '0;
    DrawX     = 10'd0;
    DrawY     = 10'd0;
    test_reset();
    test_move_up();
    test_priority();
    test_clamp();
    test_head_on();
    test_fire();
    test_reset_mid_cooldown();
    test_pixel();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tank_array_ctrl.md
TANK_ARRAY_CTRL -- requirements
Module: tank_array_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- NUM_TANKS, 2, number of independently controlled tanks (1..4)
- NUM_KEYS, 6, keycode slots per USB report
- STEP, 10'd1, pixels moved per frame
- WIDTH, 10'd32, sprite width in pixels
- HEIGHT, 10'd32, sprite height in pixels
- COOLDOWN_FRAMES, 8'd30, frames between shots
REQ-002 Ports, one per line: name, direction, width, meaning. Clock is Clk; reset is Reset_n, asynchronous, active-low:
- Clk, in, 1, 50 MHz system clock
- Reset_n, in, 1, async active-low reset
- frame_clk, in, 1, ~60 Hz frame strobe (asynchronous level)
- keycodes, in, NUM_KEYS*8, packed USB keycode slots; 8'h00 means empty
- DrawX, in, 10, current pixel X
- DrawY, in, 10, current pixel Y
- tank_X, out, NUM_TANKS*10, packed X position per tank
- tank_Y, out, NUM_TANKS*10, packed Y position per tank
- tank_dir, out, NUM_TANKS*3, packed facing per tank
- fire_pulse, out, NUM_TANKS, one-Clk shot strobe per tank
- is_tank, out, 1, pixel inside any tank
- tank_id, out, 2, lowest index of tank covering pixel; 0 when is_tank=0

Function
REQ-003 frame_clk SHALL pass through a 2-flop synchroniser; frame_tick SHALL be a 1-Clk pulse on its synchronised rising edge; all state SHALL update only on frame_tick.
REQ-004 A key SHALL count as held if any keycode slot equals it; each tank's up/down/left/right/fire keys SHALL come from the package keymap (tank 0: 1A/16/04/07/2C; tank 1: 52/51/50/4F/58).
REQ-005 Move priority per tank SHALL be up > down > left > right; no move key means no motion; there is no momentum.
REQ-006 tank_dir SHALL encode 1=up, 2=right, 3=left, 4=down, and SHALL update on every frame_tick with a move key held, even if the move is blocked.
REQ-007 Candidate position SHALL be clamped to X in [0, 640-WIDTH] and Y in [0, 480-HEIGHT]; no bounce.
REQ-008 A candidate that overlaps any other tank's current or candidate box SHALL be discarded and the tank SHALL hold position; head-on approaches therefore hold both tanks.
REQ-009 Box overlap SHALL use inclusive extents [X, X+WIDTH-1] by [Y, Y+HEIGHT-1], computed at 11 bits to avoid wrap.
REQ-010 Each tank SHALL have a fire FSM with states READY, COOLDOWN, WAIT_RELEASE:
- READY with fire held at frame_tick: assert fire_pulse for that Clk, load counter with COOLDOWN_FRAMES, go to COOLDOWN
- COOLDOWN: decrement counter per frame_tick; at 0 go to WAIT_RELEASE if fire held, else READY
- WAIT_RELEASE: go to READY on the first frame_tick with fire released
REQ-011 Firing SHALL NOT block movement; a tank may move and fire on the same frame_tick.
REQ-012 is_tank and tank_id SHALL be combinational from DrawX/DrawY against the registered positions using inclusive extents.
REQ-013 fire_pulse SHALL be registered and high for exactly one Clk per shot.

Reset
REQ-014 On Reset_n low, tank i SHALL take its position from the package start table (tank 0 at (500,240), tank 1 at (100,240)), with tank_dir=1, fire FSM READY, counter 0, fire_pulse 0 and the synchroniser cleared.
REQ-015 Reset SHALL take effect asynchronously mid-frame or mid-cooldown; release SHALL be synchronised to Clk, and no fire_pulse SHALL occur before the first frame_tick after release.

Structure
REQ-016 Package tank_pkg SHALL hold the dir_t and fire_state_t enums, the keymap table, the start-position table and the screen constants 640/480.
REQ-017 Sub-module tank_fire_fsm (one per tank, generated) SHALL implement REQ-010/013; movement and collision logic SHALL stay in the top level.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Hold 1A for 10 frames from reset: tank0 Y goes 240 to 230, dir=1; tank1 is unchanged.
- tank0 at X=607 holding 07 for 5 frames: X stays 608 (=640-32), dir=2.
- tank0 at (200,240) and tank1 at (233,240), both driving toward each other: neither moves; dirs are 2 and 3.
- Hold 2C for 70 frames: exactly 2 fire_pulses are seen, the second only after a release; releasing at frame 31 and re-pressing gives a shot at the first press frame.
- Reset_n low while COOLDOWN=12: all outputs return to reset values with no clock edge; no pulse before the first frame_tick after release.
- Pixel (500,240) gives is_tank=1, tank_id=0; pixel (532,240) gives is_tank=0.
